p16_proj_driver: RTL and testbench
==================================

Name: p16_proj_driver

Overview:
- Chip-side driver for one packed Tiny Tapeout project slot.
- Produces the 18-bit project input bundle: {uio_in[7:0], ui_in[7:0], rst_n, clk}.
- Consumes the 24-bit project output bundle: {uio_oe[7:0], uio_out[7:0], uo_out[7:0]}.
- A host issues commands over a valid/ready channel: set inputs, run N project clocks, or run a reset sequence. Each command returns one sampled output word on a response channel.

Parameters:
- HALF_DIV, 2, system clocks per project-clock half-period (legal range 1..255).
- RST_CYCLES, 4, project clock cycles held in reset during a RESET op (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 SET, 01 STEP, 10 RESET, 11 reserved
- cmd_data  in  16  {uio, ui} values; used by SET only
- cmd_cnt  in  8  project clock count; used by STEP only
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_ow  out  24  sampled project output bundle
- rsp_err  out  1  reserved opcode was received
- iw  out  18  project input bundle {uio_in, ui_in, p_rst_n, p_clk}
- ow  in  24  project output bundle

Behaviour:
- Reset values:
  - iw = 0, so p_clk=0, p_rst_n=0 and the project is held in reset until the first RESET op completes.
  - cmd_ready=0, rsp_valid=0, rsp_ow=0, rsp_err=0.
  - FSM in IDLE.
- FSM states: IDLE, HIGH, LOW, RESP.
- IDLE:
  - cmd_ready=1.
  - An accepted command is decoded in the same cycle; cmd_ready drops the next cycle.
- SET:
  - ui/uio registers load cmd_data; the new value is visible on iw the cycle after acceptance.
  - FSM goes to RESP. rsp_ow samples ow on the acceptance cycle.
- STEP with cmd_cnt=N:
  - N=0: go directly to RESP; sample ow on the acceptance cycle.
  - N>0: load remaining count = N and go to HIGH.
- RESET:
  - p_rst_n is driven 0 from the next cycle.
  - Remaining count = RST_CYCLES; go to HIGH.
  - After the final LOW phase, p_rst_n returns to 1 on the same edge that enters RESP.
- Reserved opcode: go to RESP with rsp_err=1. iw is unchanged and rsp_ow samples ow.
- HIGH: p_clk=1 for exactly HALF_DIV system cycles, then go to LOW.
- LOW:
  - p_clk=0 for exactly HALF_DIV system cycles, then decrement the remaining count.
  - Count reaches 0: go to RESP, capturing ow on the last LOW cycle.
  - Otherwise: go back to HIGH.
- Project clock cycle = 2*HALF_DIV system clocks with 50% duty; p_clk is registered and glitch-free.
- RESP:
  - rsp_valid=1; rsp_ow and rsp_err stay stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid=0 and the FSM returns to IDLE the next cycle, with cmd_ready=1 in that cycle.
  - Back-to-back minimum between accepted commands: 2 system cycles.
- ui_in/uio_in hold their last SET value across STEP and RESET ops.
- Counters: remaining count is 8 bits; the half-period counter is 8 bits and counts HALF_DIV-1 down to 0.
- Async reset mid-operation:
  - All state returns immediately to reset values. p_clk is forced to 0 without waiting for the half-period.
  - Any pending response is discarded.
- cmd_valid while the FSM is not in IDLE is ignored; cmd_ready=0, so nothing is accepted.

Optional Feature:
- Macro: P16_DRV_UIO_LOOPBACK_EN
- Defined: for each bit i, iw uio_in[i] = ow.uio_oe[i] ? ow.uio_out[i] : uio_reg[i]. This emulates a bidirectional pad readback. The loopback is a combinational path ow -> iw; this is permitted because the project side is combinational-free on that path.
- Undefined: uio_in = uio_reg unconditionally and there is no ow -> iw path.

Test Plan:
- Reset then idle: after rst_n release, iw=18'h00000, cmd_ready=1, rsp_valid=0.
- RESET op with HALF_DIV=2, RST_CYCLES=4:
  - Exactly 4 p_clk rising edges, 4 system cycles apart, all while p_rst_n=0.
  - p_rst_n=1 when rsp_valid rises; rsp_err=0.
- SET cmd_data=16'hA55A:
  - iw[17:2]=16'hA55A one cycle after acceptance; response returned; p_clk toggles never.
- STEP cmd_cnt=3 with the project model counting clocks on uo_out:
  - Exactly 3 p_clk pulses; rsp_ow[7:0]=8'h03 relative to the post-reset count.
  - cmd_cnt=0 yields 0 pulses and an immediate response.
- Response backpressure: hold rsp_ready=0 for 10 cycles.
  - rsp_valid stays 1 with rsp_ow stable; cmd_ready stays 0.
  - A cmd_valid pulse in this window is not accepted.
- Reserved op 2'b11: rsp_err=1 and iw unchanged.
- Async reset asserted mid-STEP while p_clk=1: p_clk=0 and p_rst_n=0 immediately.
- Loopback, with P16_DRV_UIO_LOOPBACK_EN defined: uio_oe=8'h0F, uio_out=8'h05, uio_reg=8'hF0 -> uio_in=8'hF5.

Source files
------------

// File: rtl/p16_proj_driver.sv
// p16_proj_driver: host-command driver for one Tiny Tapeout project slot (clock, reset, ui/uio stimulus, output sampling).
// Define P16_DRV_UIO_LOOPBACK_EN to feed enabled uio outputs back onto uio_in.
module p16_proj_driver #(
  parameter int HALF_DIV   = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  input  logic [7:0]  cmd_cnt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_ow,
  output logic        rsp_err,
  output logic [17:0] iw,
  input  logic [23:0] ow
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, RESP} state_t;
  localparam logic [7:0] HALF_LD = 8'(HALF_DIV - 1);
  localparam logic [7:0] RST_LD  = 8'(RST_CYCLES);
  state_t      state_q, state_d;
  logic [7:0]  ui_q, ui_d, uio_q, uio_d, rem_q, rem_d, half_q, half_d, uio_in;
  logic        p_clk_q, p_clk_d, p_rst_n_q, p_rst_n_d, rst_op_q, rst_op_d, rdy_q, err_q, err_d;
  logic [23:0] ow_q, ow_d;
  logic        run;
  assign run = (cmd_op == 2'b01 && cmd_cnt != 8'd0) || cmd_op == 2'b10;
  always_comb begin
    state_d   = state_q;
    ui_d      = ui_q;
    uio_d     = uio_q;
    rem_d     = rem_q;
    half_d    = half_q;
    p_clk_d   = p_clk_q;
    p_rst_n_d = p_rst_n_q;
    rst_op_d  = rst_op_q;
    err_d     = err_q;
    ow_d      = ow_q;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        ow_d    = ow;
        err_d   = cmd_op == 2'b11;
        state_d = run ? HIGH : RESP;
        if (cmd_op == 2'b00) {uio_d, ui_d} = cmd_data;
        if (run) begin
          p_clk_d  = 1'b1;
          half_d   = HALF_LD;
          rem_d    = cmd_op[1] ? RST_LD : cmd_cnt;
          rst_op_d = cmd_op[1];
          if (cmd_op[1]) p_rst_n_d = 1'b0;
        end
      end
      HIGH: begin
        half_d = half_q == 8'd0 ? HALF_LD : half_q - 8'd1;
        if (half_q == 8'd0) begin
          state_d = LOW;
          p_clk_d = 1'b0;
        end
      end
      LOW: begin
        half_d = half_q == 8'd0 ? HALF_LD : half_q - 8'd1;
        if (half_q == 8'd0) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = RESP;
            ow_d    = ow;
            err_d   = 1'b0;
            if (rst_op_q) p_rst_n_d = 1'b1;
          end else begin
            state_d = HIGH;
            p_clk_d = 1'b1;
          end
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ui_q      <= '0;
      uio_q     <= '0;
      rem_q     <= '0;
      half_q    <= '0;
      p_clk_q   <= 1'b0;
      p_rst_n_q <= 1'b0;
      rst_op_q  <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      ow_q      <= '0;
    end else begin
      state_q   <= state_d;
      ui_q      <= ui_d;
      uio_q     <= uio_d;
      rem_q     <= rem_d;
      half_q    <= half_d;
      p_clk_q   <= p_clk_d;
      p_rst_n_q <= p_rst_n_d;
      rst_op_q  <= rst_op_d;
      rdy_q     <= state_d == IDLE;
      err_q     <= err_d;
      ow_q      <= ow_d;
    end
  end
`ifdef P16_DRV_UIO_LOOPBACK_EN
  assign uio_in = (ow[23:16] & ow[15:8]) | (~ow[23:16] & uio_q);
`else
  assign uio_in = uio_q;
`endif
  assign iw        = {uio_in, ui_q, p_rst_n_q, p_clk_q};
  assign cmd_ready = rdy_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_ow    = ow_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_p16_proj_driver.sv
// tb_p16_proj_driver: directed checks of p16_proj_driver against a clock-counting project model.
module tb_p16_proj_driver;
  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_cnt, oe, out, pcnt;
  logic [23:0] rsp_ow, ow, hold;
  logic [17:0] iw, iw_nx, ib;
  logic        rv_nx, cr_nx;
  int          n_vec = 0, n_bad = 0, edges = 0, edges_hi = 0, sp_err = 0, mark = 0, e0, h0, bad;
  time         last_t = 0;
  wire         p_clk = iw[0];
  wire         p_rst = iw[1];

  always #5 clk = ~clk;

  p16_proj_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ow(rsp_ow), .rsp_err(rsp_err),
    .iw(iw), .ow(ow)
  );

  // project model: uo_out counts p_clk rising edges taken out of reset
  always @(posedge p_clk or negedge p_rst)
    if (!p_rst) pcnt <= 8'd0;
    else pcnt <= pcnt + 8'd1;
  assign ow = {oe, out, pcnt};

  always @(posedge p_clk) begin
    if (edges > mark && $time - last_t != 40) sp_err <= sp_err + 1;
    if (p_rst) edges_hi <= edges_hi + 1;
    edges  <= edges + 1;
    last_t <= $time;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = c;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    iw_nx = iw; rv_nx = rsp_valid; cr_nx = cmd_ready;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("rsp_timeout", 1, 0);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'b00;
    cmd_data = 16'h0; cmd_cnt = 8'h0; oe = 8'h00; out = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_iw", 32'(iw), 0);
    check("rst_rdy", 32'(cmd_ready), 0);
    check("rst_rv", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rdy", 32'(cmd_ready), 1);
    check("idle_iw", 32'(iw), 0);
    check("idle_rv", 32'(rsp_valid), 0);

    mark = edges; e0 = edges; h0 = edges_hi;
    issue(2'b10, 16'h0, 8'h0);
    check("reset_prst_low", 32'(iw_nx[1]), 0);
    wait_rsp();
    check("reset_edges", 32'(edges - e0), 4);
    check("reset_edges_in_rst", 32'(edges_hi - h0), 0);
    check("reset_spacing", 32'(sp_err), 0);
    check("reset_prst_rel", 32'(iw[1]), 1);
    check("reset_err", 32'(rsp_err), 0);
    check("reset_ow", 32'(rsp_ow), 0);
    ack();

    out = 8'h3C;
    mark = edges; e0 = edges;
    issue(2'b00, 16'hA55A, 8'h0);
    check("set_iw", 32'(iw_nx[17:2]), 32'h0000A55A);
    check("set_rdy_drop", 32'(cr_nx), 0);
    wait_rsp();
    check("set_ow", 32'(rsp_ow), 32'h00003C00);
    check("set_edges", 32'(edges - e0), 0);
    ack();

    mark = edges; e0 = edges;
    issue(2'b01, 16'h0, 8'd3);
    wait_rsp();
    check("step3_edges", 32'(edges - e0), 3);
    check("step3_ow", 32'(rsp_ow), 32'h00003C03);
    check("step3_spacing", 32'(sp_err), 0);
    check("step3_hold_in", 32'(iw[17:2]), 32'h0000A55A);
    ack();

    e0 = edges;
    issue(2'b01, 16'h0, 8'd0);
    check("step0_rv", 32'(rv_nx), 1);
    wait_rsp();
    check("step0_edges", 32'(edges - e0), 0);
    check("step0_ow", 32'(rsp_ow), 32'h00003C03);
    ack();

    e0 = edges;
    issue(2'b00, 16'h1234, 8'h0);
    wait_rsp();
    hold = rsp_ow; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = (i == 3); cmd_op = 2'b01; cmd_cnt = 8'd5;
      if (!rsp_valid || rsp_ow !== hold || cmd_ready) bad++;
    end
    cmd_valid = 1'b0;
    check("bp_stable", 32'(bad), 0);
    check("bp_ow", 32'(hold), 32'h00003C03);
    ack();
    repeat (3) @(negedge clk);
    check("bp_no_accept_edges", 32'(edges - e0), 0);
    check("bp_no_accept_rv", 32'(rsp_valid), 0);
    check("bp_iw", 32'(iw[17:2]), 32'h00001234);

    ib = iw;
    issue(2'b11, 16'hFFFF, 8'd7);
    check("rsv_iw", 32'(iw_nx), 32'(ib));
    wait_rsp();
    check("rsv_err", 32'(rsp_err), 1);
    check("rsv_ow", 32'(rsp_ow), 32'h00003C03);
    ack();

    issue(2'b00, 16'hF011, 8'h0);
    wait_rsp();
    check("lb_err_clear", 32'(rsp_err), 0);
    ack();
    oe = 8'h0F; out = 8'h05;
    @(negedge clk);
`ifdef P16_DRV_UIO_LOOPBACK_EN
    check("lb_uio", 32'(iw[17:10]), 32'h000000F5);
`else
    check("lb_uio", 32'(iw[17:10]), 32'h000000F0);
`endif
    check("lb_ui", 32'(iw[9:2]), 32'h00000011);
    oe = 8'h00; out = 8'h00;

    begin
      int n = 0;
      issue(2'b01, 16'h0, 8'd10);
      while (!p_clk && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("ar_pclk_timeout", 1, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("ar_iw", 32'(iw), 0);
    check("ar_rdy", 32'(cmd_ready), 0);
    check("ar_rv", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_idle_rdy", 32'(cmd_ready), 1);
    check("ar_rsp_dropped", 32'(rsp_valid), 0);
    check("ar_iw_idle", 32'(iw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
